// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : uart_boot_loader
//  Function : Checks UART-assembled words against a length header and writes
//             the payload to instruction memory through a small FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_boot_loader #(
    parameter int IMEM_ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       data_valid,
    input  logic [31:0]                data_out,
    input  logic [31:0]                byte_address,
    output logic                       mem_req,
    output logic [IMEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]                mem_wdata,
    input  logic                       mem_ready,
    output logic                       load_done,
    output logic                       load_error,
    output logic                       cpu_reset
);

    localparam int                   c_ptr_w     = $clog2(FIFO_DEPTH);
    localparam logic [31:0]          c_max_bytes = 32'd4 << IMEM_ADDR_WIDTH;
    localparam logic [c_ptr_w:0]     c_depth     = FIFO_DEPTH[c_ptr_w:0];
    localparam logic [c_ptr_w:0]     c_cnt_one   = (c_ptr_w + 1)'(1);
    localparam logic [IMEM_ADDR_WIDTH:0] c_rem_one = (IMEM_ADDR_WIDTH + 1)'(1);

    typedef enum logic [2:0] {
        WAIT_HDR = 3'd0,
        LOAD     = 3'd1,
        DRAIN    = 3'd2,
        DONE     = 3'd3,
        ERROR    = 3'd4
    } state_t;

    state_t                       r_state;
    state_t                       w_state_next;
    logic [31:0]                  r_exp_addr;
    logic [IMEM_ADDR_WIDTH:0]     r_remaining;
    logic [IMEM_ADDR_WIDTH-1:0]   r_word_idx;

    logic [IMEM_ADDR_WIDTH-1:0]   r_fifo_addr [FIFO_DEPTH];
    logic [31:0]                  r_fifo_data [FIFO_DEPTH];
    logic [c_ptr_w-1:0]           r_wr_ptr;
    logic [c_ptr_w-1:0]           r_rd_ptr;
    logic [c_ptr_w:0]             r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_hdr_ok;
    logic w_flush;

    always_comb begin
        w_empty      = (r_count == '0);
        w_full       = (r_count == c_depth);
        w_pop        = !w_empty && mem_ready;
        w_hdr_ok     = (byte_address == 32'd0) && (data_out != 32'd0) &&
                       (data_out[1:0] == 2'b00) && (data_out <= c_max_bytes);
        w_push       = 1'b0;
        w_state_next = r_state;
        case (r_state)
            WAIT_HDR: begin
                if (data_valid) begin
                    w_state_next = w_hdr_ok ? LOAD : ERROR;
                end
            end
            LOAD: begin
                // A full FIFO only takes a new word if the head leaves this cycle.
                if (data_valid) begin
                    if ((byte_address != r_exp_addr) || (w_full && !w_pop)) begin
                        w_state_next = ERROR;
                    end else begin
                        w_push = 1'b1;
                        if (r_remaining == c_rem_one) begin
                            w_state_next = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (w_empty || ((r_count == c_cnt_one) && w_pop)) begin
                    w_state_next = DONE;
                end
            end
            DONE, ERROR: ;
            default: w_state_next = ERROR;
        endcase
        w_flush = (w_state_next == ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= WAIT_HDR;
            r_exp_addr  <= 32'd4;
            r_remaining <= '0;
            r_word_idx  <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == WAIT_HDR) && data_valid && w_hdr_ok) begin
                r_remaining <= data_out[IMEM_ADDR_WIDTH+2:2];
            end
            if (w_push) begin
                r_exp_addr  <= r_exp_addr + 32'd4;
                r_remaining <= r_remaining - c_rem_one;
                r_word_idx  <= r_word_idx + IMEM_ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= r_word_idx;
            r_fifo_data[r_wr_ptr] <= data_out;
        end
    end

    assign mem_req    = !w_empty;
    assign mem_addr   = w_empty ? '0 : r_fifo_addr[r_rd_ptr];
    assign mem_wdata  = w_empty ? '0 : r_fifo_data[r_rd_ptr];
    assign load_done  = (r_state == DONE);
    assign load_error = (r_state == ERROR);
    assign cpu_reset  = (r_state != DONE);

endmodule
`default_nettype wire
